// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALUOp encodings, ALU control codes and R-type funct codes.
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpRtype = 2'b10,
    AluOpSlt   = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    AluCtrlNop = 4'b0000,
    AluCtrlAdd = 4'b0010,
    AluCtrlSub = 4'b0110,
    AluCtrlSlt = 4'b0111
  } alu_ctrl_e;

  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctAddu = 6'h21;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctSubu = 6'h23;
  localparam logic [5:0] FunctSlt  = 6'h2A;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALU control decode from ALUOp and the R-type funct field.
module alu_control_decode
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = AluCtrlNop;
    unique case (alu_op_e'(alu_op_i))
      AluOpAdd: alu_control_o = AluCtrlAdd;
      AluOpSub: alu_control_o = AluCtrlSub;
      AluOpSlt: alu_control_o = AluCtrlSlt;
      AluOpRtype: begin
        case (funct_i)
          FunctAdd, FunctAddu: alu_control_o = AluCtrlAdd;
          FunctSub, FunctSubu: alu_control_o = AluCtrlSub;
          FunctSlt:            alu_control_o = AluCtrlSlt;
          default:             alu_control_o = AluCtrlNop;
        endcase
      end
      default: alu_control_o = AluCtrlNop;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_dest,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_hazard
);

  logic [DATA_W-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q, imm_d, imm_q;
  logic [REG_W-1:0]  rs_d, rs_q, rt_d, rt_q, dest_d, dest_q;
  logic [5:0]        funct_d, funct_q;
  logic [1:0]        alu_op_d, alu_op_q;
  logic              alu_src_d, alu_src_q;
  logic              mem_read_d, mem_read_q, mem_write_d, mem_write_q;
  logic              reg_write_d, reg_write_q, mem_to_reg_d, mem_to_reg_q;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  always_comb begin
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    dest_d       = dest_q;
    funct_d      = funct_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (flush) begin
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      rs_d         = '0;
      rt_d         = '0;
      dest_d       = '0;
      funct_d      = '0;
      alu_op_d     = '0;
      alu_src_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!stall) begin
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      rs_d         = id_rs;
      rt_d         = id_rt;
      // Destination is resolved here; rt_q is still kept for hazard checks.
      dest_d       = id_reg_dst ? id_rd : id_rt;
      funct_d      = id_funct;
      alu_op_d     = id_alu_op;
      alu_src_d    = id_alu_src;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      reg_write_d  = id_reg_write;
      mem_to_reg_d = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      funct_q      <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      funct_q      <= funct_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB; $0 is never forwarded.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
      fwd_rs = memwb_result;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
      fwd_rt = memwb_result;
    end
  end

  alu_control_decode u_alu_control_decode (
    .alu_op_i      (alu_op_q),
    .funct_i       (funct_q),
    .alu_control_o (alu_control)
  );

  assign alu_a         = fwd_rs;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_dest       = dest_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

  assign load_use_hazard = mem_read_q && (rt_q != '0) && ((rt_q == id_rs) || (rt_q == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, then random stimulus vs a model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, load_use_hazard;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_funct        (id_funct),
    .id_alu_op       (id_alu_op),
    .id_alu_src      (id_alu_src),
    .id_reg_dst      (id_reg_dst),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .id_reg_write    (id_reg_write),
    .id_mem_to_reg   (id_mem_to_reg),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .alu_control     (alu_control),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .ex_store_data   (ex_store_data),
    .ex_dest         (ex_dest),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .load_use_hazard (load_use_hazard)
  );

  // One directed step: id_* applied before the edge, forwarding/probe inputs after it.
  typedef struct {
    logic        rst, stl, fl;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [1:0]  op;
    logic        src, dst, mr, mw, rw, m2r;
    logic        exw, mww;
    logic [4:0]  exrd, mwrd, nrs, nrt;
    logic [31:0] exres, mwres;
    logic [3:0]  e_ctrl, e_flg;
    logic [31:0] e_a, e_b, e_sd;
    logic [4:0]  e_dest;
    logic        e_hz;
  } vec_t;

  // Abstract view of the instruction currently sitting in EX.
  typedef struct {
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs, rt, dest;
    logic [5:0]  funct;
    logic [1:0]  op;
    logic        src, mr, mw, rw, m2r;
  } ex_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] funct);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd7;
    if (funct == 6'h20 || funct == 6'h21) return 4'd2;
    if (funct == 6'h22 || funct == 6'h23) return 4'd6;
    if (funct == 6'h2A) return 4'd7;
    return 4'd0;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] d);
    if (r != 0 && exmem_reg_write && exmem_rd == r) return exmem_result;
    if (r != 0 && memwb_reg_write && memwb_rd == r) return memwb_result;
    return d;
  endfunction

  task automatic check_all(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] sd, input logic [4:0] dest,
                           input logic [3:0] flg, input logic hz);
    check({tag, " alu_control"}, 32'(alu_control), 32'(ctrl));
    check({tag, " alu_a"}, alu_a, a);
    check({tag, " alu_b"}, alu_b, b);
    check({tag, " store_data"}, ex_store_data, sd);
    check({tag, " ex_dest"}, 32'(ex_dest), 32'(dest));
    check({tag, " flags"}, 32'({ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg}),
          32'(flg));
    check({tag, " hazard"}, 32'(load_use_hazard), 32'(hz));
  endtask

  initial begin
    ex_t m;
    vec_t v;
    logic [5:0] fsel[8];

    // reset state
    vecs[0]  = '{rst: 1, e_ctrl: 4'h2, default: 0};
    // add $3,$1,$2
    vecs[1]  = '{rs_d: 5, rt_d: 7, rs: 1, rt: 2, rd: 3, funct: 6'h20, op: 2, dst: 1, rw: 1,
                 e_ctrl: 4'h2, e_a: 5, e_b: 7, e_sd: 7, e_dest: 3, e_flg: 4'b0010, default: 0};
    // rs=4 forwarded from EX/MEM over MEM/WB
    vecs[2]  = '{rs_d: 1, rt_d: 9, rs: 4, rt: 6, rw: 1, exw: 1, exrd: 4, exres: 32'h10,
                 mww: 1, mwrd: 4, mwres: 32'h20,
                 e_ctrl: 4'h2, e_a: 32'h10, e_b: 9, e_sd: 9, e_dest: 6, e_flg: 4'b0010,
                 default: 0};
    // stall with different id_*: held; EX/MEM dropped so MEM/WB forwards
    vecs[3]  = '{stl: 1, rs_d: 32'hDEAD, rt_d: 32'hBEEF, rs: 7, rt: 8, rd: 12, op: 3, dst: 1,
                 mr: 1, mww: 1, mwrd: 4, mwres: 32'h20,
                 e_ctrl: 4'h2, e_a: 32'h20, e_b: 9, e_sd: 9, e_dest: 6, e_flg: 4'b0010,
                 default: 0};
    // $0 is never forwarded
    vecs[4]  = '{rs_d: 32'h33, rt_d: 32'h44, exw: 1, exrd: 0, exres: 32'hFF,
                 mww: 1, mwrd: 0, mwres: 32'hEE,
                 e_ctrl: 4'h2, e_a: 32'h33, e_b: 32'h44, e_sd: 32'h44, default: 0};
    // lw $5 in EX, ID reads $5 as rs
    vecs[5]  = '{rs_d: 32'h100, rt_d: 32'h77, imm: 4, rs: 1, rt: 5, src: 1, mr: 1, rw: 1,
                 m2r: 1, nrs: 5, nrt: 9,
                 e_ctrl: 4'h2, e_a: 32'h100, e_b: 4, e_sd: 32'h77, e_dest: 5, e_flg: 4'b1011,
                 e_hz: 1, default: 0};
    // flush -> bubble
    vecs[6]  = '{fl: 1, rs_d: 5, rs: 1, rt: 2, rd: 3, dst: 1, rw: 1, mr: 1, op: 1,
                 e_ctrl: 4'h2, default: 0};
    // sw, rt forwarded from MEM/WB, imm on B
    vecs[7]  = '{rs_d: 32'h40, rt_d: 1, imm: 8, rs: 2, rt: 7, src: 1, mw: 1,
                 mww: 1, mwrd: 7, mwres: 32'hABCD,
                 e_ctrl: 4'h2, e_a: 32'h40, e_b: 8, e_sd: 32'hABCD, e_dest: 7,
                 e_flg: 4'b0100, default: 0};
    // stall and flush together -> bubble
    vecs[8]  = '{stl: 1, fl: 1, rs_d: 32'h99, rs: 3, rt: 3, rw: 1, mr: 1,
                 e_ctrl: 4'h2, default: 0};
    // R-type funct 0x24 -> NOP code
    vecs[9]  = '{rs_d: 3, rt_d: 4, rs: 1, rt: 2, rd: 9, funct: 6'h24, op: 2, dst: 1, rw: 1,
                 e_ctrl: 4'h0, e_a: 3, e_b: 4, e_sd: 4, e_dest: 9, e_flg: 4'b0010, default: 0};
    // slti
    vecs[10] = '{rs_d: 8, rt_d: 5, imm: 32'hFFFFFFFF, rs: 3, rt: 4, op: 3, src: 1, rw: 1,
                 e_ctrl: 4'h7, e_a: 8, e_b: 32'hFFFFFFFF, e_sd: 5, e_dest: 4,
                 e_flg: 4'b0010, default: 0};
    // sub, rt matched in both stages: EX/MEM wins
    vecs[11] = '{rs_d: 32'h10, rt_d: 32'h20, rs: 1, rt: 2, rd: 10, funct: 6'h22, op: 2,
                 dst: 1, rw: 1, exw: 1, exrd: 2, exres: 32'h99, mww: 1, mwrd: 2,
                 mwres: 32'h55,
                 e_ctrl: 4'h6, e_a: 32'h10, e_b: 32'h99, e_sd: 32'h99, e_dest: 10,
                 e_flg: 4'b0010, default: 0};
    // lw $6, ID reads $6 as rt
    vecs[12] = '{rs: 1, rt: 6, src: 1, mr: 1, rw: 1, m2r: 1, nrs: 3, nrt: 6,
                 e_ctrl: 4'h2, e_dest: 6, e_flg: 4'b1011, e_hz: 1, default: 0};
    // lw $0 never raises a hazard
    vecs[13] = '{rs: 1, rt: 0, src: 1, mr: 1, rw: 1, m2r: 1, nrs: 0, nrt: 0,
                 e_ctrl: 4'h2, e_flg: 4'b1011, default: 0};

    reset = 1; stall = 0; flush = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_funct = 0; id_alu_op = 0; id_alu_src = 0; id_reg_dst = 0; id_mem_read = 0;
    id_mem_write = 0; id_reg_write = 0; id_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      reset = v.rst; stall = v.stl; flush = v.fl;
      id_rs_data = v.rs_d; id_rt_data = v.rt_d; id_imm = v.imm;
      id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_funct = v.funct; id_alu_op = v.op;
      id_alu_src = v.src; id_reg_dst = v.dst; id_mem_read = v.mr; id_mem_write = v.mw;
      id_reg_write = v.rw; id_mem_to_reg = v.m2r;
      @(posedge clk); #1;
      reset = 0; stall = 0; flush = 0;
      id_rs = v.nrs; id_rt = v.nrt;
      exmem_reg_write = v.exw; exmem_rd = v.exrd; exmem_result = v.exres;
      memwb_reg_write = v.mww; memwb_rd = v.mwrd; memwb_result = v.mwres;
      #1;
      check_all($sformatf("v%0d", i), v.e_ctrl, v.e_a, v.e_b, v.e_sd, v.e_dest, v.e_flg,
                v.e_hz);
    end

    fsel[0] = 6'h20; fsel[1] = 6'h21; fsel[2] = 6'h22; fsel[3] = 6'h23;
    fsel[4] = 6'h2A; fsel[5] = 6'h24; fsel[6] = 6'h00; fsel[7] = 6'h25;
    m = '{default: 0};
    for (int i = 0; i < 300; i++) begin
      reset = (i == 0) || ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 31));
      id_funct = fsel[$urandom_range(0, 7)]; id_alu_op = 2'($urandom);
      id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom); id_mem_read = 1'($urandom);
      id_mem_write = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      @(posedge clk);
      if (reset || flush) begin
        m = '{default: 0};
      end else if (!stall) begin
        m.rs_d = id_rs_data; m.rt_d = id_rt_data; m.imm = id_imm;
        m.rs = id_rs; m.rt = id_rt; m.dest = id_reg_dst ? id_rd : id_rt;
        m.funct = id_funct; m.op = id_alu_op; m.src = id_alu_src;
        m.mr = id_mem_read; m.mw = id_mem_write; m.rw = id_reg_write; m.m2r = id_mem_to_reg;
      end
      #1;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      #1;
      check_all($sformatf("r%0d", i), ref_ctrl(m.op, m.funct), ref_fwd(m.rs, m.rs_d),
                m.src ? m.imm : ref_fwd(m.rt, m.rt_d), ref_fwd(m.rt, m.rt_d), m.dest,
                {m.mr, m.mw, m.rw, m.m2r},
                m.mr && (m.rt != 0) && ((m.rt == id_rs) || (m.rt == id_rt)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
